lc3_regfile_sb: RTL and testbench

Parametrised LC-3 general-purpose register file with a per-register scoreboard, N read ports, one write port and an NZP condition-code register. It replaces the fixed 8×16, two-read-port file in the datapath. It is sized for a pipelined core: decode reserves a destination register and writeback releases it. Read ports report whether their source register still has a write pending.

---
 rtl/lc3_rf_pkg.sv | 16 +
 rtl/lc3_regfile_sb_if.sv | 32 +++
 rtl/lc3_regfile_sb_cc_gen.sv | 13 +
 rtl/lc3_regfile_sb.sv | 67 ++++++
 tb/tb_lc3_regfile_sb.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lc3_rf_pkg.sv
// Shared constants and condition-code helper for the LC-3 register file and branch unit.
package lc3_rf_pkg;

   localparam logic [2:0] CC_N     = 3'b100;
   localparam logic [2:0] CC_Z     = 3'b010;
   localparam logic [2:0] CC_P     = 3'b001;
   localparam logic [2:0] CC_RESET = CC_Z;

   // Width-independent core of the NZP rule; callers supply the sign bit and a zero flag.
   function automatic logic [2:0] nzp_of(input logic sign, input logic zero);
      if (zero)      return CC_Z;
      else if (sign) return CC_N;
      else           return CC_P;
   endfunction

endpackage

// File: rtl/lc3_regfile_sb_if.sv
// Bus between decode/writeback (master) and the scoreboarded register file (slave).
interface lc3_regfile_sb_if #(
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 8,
   parameter int NUM_RD   = 3
);
   localparam int AW = $clog2(NUM_REGS);

   logic [NUM_RD*AW-1:0]     rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_busy;
   logic                     wr_en;
   logic [AW-1:0]            wr_addr;
   logic [DATA_W-1:0]        wr_data;
   logic                     wr_ld_cc;
   logic                     rsv_en;
   logic [AW-1:0]            rsv_addr;
   logic                     rsv_ack;
   logic [NUM_REGS-1:0]      busy_vec;
   logic [2:0]               cc_nzp;

   modport master (
      output rd_addr, wr_en, wr_addr, wr_data, wr_ld_cc, rsv_en, rsv_addr,
      input  rd_data, rd_busy, rsv_ack, busy_vec, cc_nzp
   );

   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data, wr_ld_cc, rsv_en, rsv_addr,
      output rd_data, rd_busy, rsv_ack, busy_vec, cc_nzp
   );

endinterface

// File: rtl/lc3_regfile_sb_cc_gen.sv
// Combinational NZP generator; also instantiated by the branch unit.
module lc3_cc_gen
   import lc3_rf_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic [DATA_W-1:0] data,
   output logic [2:0]        nzp
);

   assign nzp = nzp_of(data[DATA_W-1], data == '0);

endmodule

// File: rtl/lc3_regfile_sb.sv
// Scoreboarded LC-3 register file: NUM_RD combinational read ports, one write port, NZP register.
// Define REGFILE_BYPASS_EN to forward the writeback value and released busy bit to same-cycle reads.
module lc3_regfile_sb
   import lc3_rf_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 8,
   parameter int NUM_RD   = 3
) (
   input logic              Clk,
   input logic              reset,
   lc3_regfile_sb_if.slave  bus
);

   localparam int AW = $clog2(NUM_REGS);

   logic [DATA_W-1:0]   r_regs [NUM_REGS];
   logic [NUM_REGS-1:0] r_busy;
   logic [2:0]          r_cc;
   logic [2:0]          w_wr_nzp;
   logic                w_rsv_ack;

   // A release by writeback in the same cycle frees the slot for an immediate re-reserve.
   assign w_rsv_ack = bus.rsv_en &&
                      (!r_busy[bus.rsv_addr] || (bus.wr_en && (bus.wr_addr == bus.rsv_addr)));

   assign bus.rsv_ack  = w_rsv_ack;
   assign bus.busy_vec = r_busy;
   assign bus.cc_nzp   = r_cc;

   lc3_cc_gen #(.DATA_W(DATA_W)) u_cc_gen (
      .data (bus.wr_data),
      .nzp  (w_wr_nzp)
   );

   always_ff @(posedge Clk) begin
      if (reset) begin
         // NOTE: the array is flops, not RAM, so it can and must be cleared by reset.
         r_regs <= '{default: '0};
         r_busy <= '0;
         r_cc   <= CC_RESET;
      end else begin
         if (bus.wr_en) begin
            r_regs[bus.wr_addr] <= bus.wr_data;
            r_busy[bus.wr_addr] <= 1'b0;
            if (bus.wr_ld_cc) r_cc <= w_wr_nzp;
         end
         // NOTE: with non-blocking assignments the last one wins, so reserve overrides release.
         if (w_rsv_ack) r_busy[bus.rsv_addr] <= 1'b1;
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [AW-1:0] w_addr;
      assign w_addr = bus.rd_addr[k*AW +: AW];
`ifdef REGFILE_BYPASS_EN
      logic w_fwd;
      assign w_fwd = bus.wr_en && (w_addr == bus.wr_addr);
      assign bus.rd_data[k*DATA_W +: DATA_W] = w_fwd ? bus.wr_data : r_regs[w_addr];
      assign bus.rd_busy[k]                  = w_fwd ? 1'b0 : r_busy[w_addr];
`else
      assign bus.rd_data[k*DATA_W +: DATA_W] = r_regs[w_addr];
      assign bus.rd_busy[k]                  = r_busy[w_addr];
`endif
   end

endmodule

// File: tb/tb_lc3_regfile_sb.sv
// Scoreboard bench for lc3_regfile_sb: default instance (16b x 8, 3 ports) and a 32b x 16, 4-port instance.
module tb_lc3_regfile_sb;

   localparam int MAXW = 32;
   localparam int MAXR = 16;
   localparam int MAXP = 4;

   typedef struct packed {
      logic                       dut;
      logic [MAXP-1:0][MAXW-1:0]  rd_data;
      logic [MAXP-1:0]            rd_busy;
      logic [MAXR-1:0]            busy_vec;
      logic [2:0]                 cc;
      logic                       chk_ack;
      logic                       ack;
   } exp_t;

   logic Clk = 1'b0;
   always #5 Clk = ~Clk;

   logic        s_reset, s_dut, s_wr_en, s_wr_ld_cc, s_rsv_en;
   logic [3:0]  s_wr_addr, s_rsv_addr;
   logic [31:0] s_wr_data;
   logic [3:0]  s_rd_addr [MAXP];
   logic        cur_dut;

   int n_checks = 0;
   int n_pass   = 0;

   lc3_regfile_sb_if #(.DATA_W(16), .NUM_REGS(8),  .NUM_RD(3)) if_a ();
   lc3_regfile_sb_if #(.DATA_W(32), .NUM_REGS(16), .NUM_RD(4)) if_b ();

   assign if_a.rd_addr  = {s_rd_addr[2][2:0], s_rd_addr[1][2:0], s_rd_addr[0][2:0]};
   assign if_a.wr_en    = !s_dut && s_wr_en;
   assign if_a.wr_addr  = s_wr_addr[2:0];
   assign if_a.wr_data  = s_wr_data[15:0];
   assign if_a.wr_ld_cc = s_wr_ld_cc;
   assign if_a.rsv_en   = !s_dut && s_rsv_en;
   assign if_a.rsv_addr = s_rsv_addr[2:0];

   assign if_b.rd_addr  = {s_rd_addr[3], s_rd_addr[2], s_rd_addr[1], s_rd_addr[0]};
   assign if_b.wr_en    = s_dut && s_wr_en;
   assign if_b.wr_addr  = s_wr_addr;
   assign if_b.wr_data  = s_wr_data;
   assign if_b.wr_ld_cc = s_wr_ld_cc;
   assign if_b.rsv_en   = s_dut && s_rsv_en;
   assign if_b.rsv_addr = s_rsv_addr;

   lc3_regfile_sb #(.DATA_W(16), .NUM_REGS(8), .NUM_RD(3)) u_dut_a (
      .Clk (Clk), .reset (s_reset), .bus (if_a)
   );
   lc3_regfile_sb #(.DATA_W(32), .NUM_REGS(16), .NUM_RD(4)) u_dut_b (
      .Clk (Clk), .reset (s_reset), .bus (if_b)
   );

   // Both instances' outputs widened to a common shape for the monitor.
   logic [MAXP-1:0][MAXW-1:0] a_data, b_data;
   logic [MAXP-1:0]           a_busy, b_busy;
   logic [MAXR-1:0]           a_bv, b_bv;
   assign a_data = {32'h0, 16'h0, if_a.rd_data[47:32], 16'h0, if_a.rd_data[31:16],
                    16'h0, if_a.rd_data[15:0]};
   assign b_data = if_b.rd_data;
   assign a_busy = {1'b0, if_a.rd_busy};
   assign b_busy = if_b.rd_busy;
   assign a_bv   = {8'h00, if_a.busy_vec};
   assign b_bv   = if_b.busy_vec;

   // Reference model: plain arrays, one set per instance.
   logic [MAXW-1:0] m_regs [2][MAXR];
   logic            m_busy [2][MAXR];
   logic [2:0]      m_cc   [2];
   exp_t            sb_q [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < MAXR; i++) begin
            m_regs[d][i] = '0;
            m_busy[d][i] = 1'b0;
         end
         m_cc[d] = 3'b010;
      end
   endtask

   // Predict this cycle's combinational outputs, queue them, then apply the coming edge to the model.
   task automatic predict();
      int          d, w, nr, np;
      logic [31:0] wd;
      logic [3:0]  a;
      exp_t        e;
      d  = int'(s_dut);
      w  = s_dut ? 32 : 16;
      nr = s_dut ? 16 : 8;
      np = s_dut ? 4 : 3;
      wd = s_dut ? s_wr_data : {16'h0, s_wr_data[15:0]};
      e  = '0;
      e.dut = s_dut;
      for (int k = 0; k < np; k++) begin
         a = s_rd_addr[k];
         e.rd_data[k] = m_regs[d][a];
         e.rd_busy[k] = m_busy[d][a];
`ifdef REGFILE_BYPASS_EN
         if (s_wr_en && a == s_wr_addr) begin
            e.rd_data[k] = wd;
            e.rd_busy[k] = 1'b0;
         end
`endif
      end
      for (int i = 0; i < nr; i++) e.busy_vec[i] = m_busy[d][i];
      e.cc      = m_cc[d];
      e.chk_ack = !s_reset;
      e.ack     = s_rsv_en && (!m_busy[d][s_rsv_addr] || (s_wr_en && s_wr_addr == s_rsv_addr));
      sb_q.push_back(e);

      if (s_reset) model_reset();
      else begin
         if (s_wr_en) begin
            m_regs[d][s_wr_addr] = wd;
            m_busy[d][s_wr_addr] = 1'b0;
            if (s_wr_ld_cc) m_cc[d] = (wd == 0) ? 3'b010 : (wd[w-1] ? 3'b100 : 3'b001);
         end
         if (e.ack) m_busy[d][s_rsv_addr] = 1'b1;
      end
   endtask

   task automatic cyc(input logic rst, input logic we, input logic [3:0] wa, input logic [31:0] wd,
                      input logic ld, input logic re, input logic [3:0] ra,
                      input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2,
                      input logic [3:0] a3);
      @(posedge Clk);
      #1;
      s_dut = cur_dut;  s_reset = rst;
      s_wr_en = we;     s_wr_addr = wa;  s_wr_data = wd;  s_wr_ld_cc = ld;
      s_rsv_en = re;    s_rsv_addr = ra;
      s_rd_addr[0] = a0; s_rd_addr[1] = a1; s_rd_addr[2] = a2; s_rd_addr[3] = a3;
      predict();
   endtask

   function automatic logic [31:0] rnd_data();
      case ($urandom_range(3))
         0:       return 32'h0;
         1:       return $urandom | 32'h8000_8000;
         default: return $urandom;
      endcase
   endfunction

   task automatic random_phase(input int n);
      int hi;
      hi = cur_dut ? 15 : 7;
      for (int i = 0; i < n; i++)
         cyc($urandom_range(39) == 0, 1'($urandom_range(1)), 4'($urandom_range(hi)), rnd_data(),
             1'($urandom_range(1)), 1'($urandom_range(1)), 4'($urandom_range(hi)),
             4'($urandom_range(hi)), 4'($urandom_range(hi)), 4'($urandom_range(hi)),
             4'($urandom_range(hi)));
   endtask

   // Monitor: outputs are always presented, so one queued expectation is consumed every cycle.
   initial begin : monitor
      exp_t e;
      logic [MAXP-1:0][MAXW-1:0] ad;
      logic [MAXP-1:0]           ab;
      logic [MAXR-1:0]           av;
      logic [2:0]                ac;
      logic                      ak;
      forever begin
         @(negedge Clk);
         if (sb_q.size() != 0) begin
            e  = sb_q.pop_front();
            ad = e.dut ? b_data : a_data;
            ab = e.dut ? b_busy : a_busy;
            av = e.dut ? b_bv   : a_bv;
            ac = e.dut ? if_b.cc_nzp  : if_a.cc_nzp;
            ak = e.dut ? if_b.rsv_ack : if_a.rsv_ack;
            for (int k = 0; k < (e.dut ? 4 : 3); k++) begin
               check($sformatf("rd_data%0d", k), 64'(ad[k]), 64'(e.rd_data[k]));
               check($sformatf("rd_busy%0d", k), 64'(ab[k]), 64'(e.rd_busy[k]));
            end
            check("busy_vec", 64'(av), 64'(e.busy_vec));
            check("cc_nzp",   64'(ac), 64'(e.cc));
            if (e.chk_ack) check("rsv_ack", 64'(ak), 64'(e.ack));
         end
      end
   end

   initial begin : stimulus
      cur_dut = 1'b0;
      s_dut = 1'b0; s_reset = 1'b1; s_wr_en = 1'b0; s_wr_addr = '0; s_wr_data = '0;
      s_wr_ld_cc = 1'b0; s_rsv_en = 1'b0; s_rsv_addr = '0;
      for (int k = 0; k < MAXP; k++) s_rd_addr[k] = '0;
      @(posedge Clk);
      #1;
      model_reset();

      // Default instance: reset state, CC rules, reserve/release, same-cycle reserve+write, bypass.
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++)
         cyc(0, 0, 0, 0, 0, 0, 0, 4'(i), 4'((i + 3) % 8), 4'((i + 5) % 8), 0);
      cyc(0, 1, 5, 32'hBEEF, 1, 0, 0, 5, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 5, 5, 5, 0);
      cyc(0, 1, 2, 32'h0000, 1, 0, 0, 2, 0, 0, 0);
      cyc(0, 1, 2, 32'h0042, 1, 0, 0, 2, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 2, 2, 2, 0);
      cyc(0, 0, 0, 0, 0, 1, 3, 3, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 3, 3, 0, 0, 0);
      cyc(0, 1, 3, 32'h1234, 0, 0, 0, 3, 3, 3, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 3, 3, 3, 0);
      cyc(0, 0, 0, 0, 0, 1, 4, 4, 0, 0, 0);
      cyc(0, 1, 4, 32'hAAAA, 0, 1, 4, 4, 4, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 4, 4, 4, 0);
      cyc(0, 1, 1, 32'h5555, 0, 0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
      cyc(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 6, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 7, 6, 7, 0, 0);
      cyc(1, 1, 6, 32'hFFFF, 1, 0, 0, 6, 7, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 6, 7, 0, 0);
      random_phase(400);

      // Wide instance: address-as-data sweep on all four ports, then a negative CC update.
      cur_dut = 1'b1;
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 16; i++) cyc(0, 1, 4'(i), 32'(i), 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 16; i += 4)
         cyc(0, 0, 0, 0, 0, 0, 0, 4'(i), 4'(i + 1), 4'(i + 2), 4'(i + 3));
      for (int i = 0; i < 16; i++)
         cyc(0, 0, 0, 0, 0, 0, 0, 4'(15 - i), 4'(i), 4'((i + 7) % 16), 4'((i + 11) % 16));
      cyc(0, 1, 9, 32'h8000_0000, 1, 0, 0, 9, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 9, 9, 9, 9);
      random_phase(300);

      // Return inputs to idle and let the monitor drain, with a bounded wait.
      @(posedge Clk);
      #1;
      s_wr_en = 1'b0; s_rsv_en = 1'b0; s_reset = 1'b0;
      for (int i = 0; i < 4 && sb_q.size() != 0; i++) @(negedge Clk);
      #1;
      check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
